// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types, constants and helpers for the block transfer sequencer
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } bts_state_t;

    localparam logic [3:0] PC_IDX     = 4'd15;
    localparam int         WORD_BYTES = 4;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'b0000, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/lowest_set16.sv
// rtl/lowest_set16.sv - combinational lowest-set-bit priority encoder for a 16-bit vector
module lowest_set16 (
    input  logic [15:0] vec,
    output logic [3:0]  idx,
    output logic        any
);

    // Scan from the top so the lowest set bit is the last assignment and wins.
    always_comb begin
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/block_transfer_sequencer.sv
// rtl/block_transfer_sequencer.sv - LDM/STM multi-cycle sequencer: one word per beat, optional base writeback
module block_transfer_sequencer #(
    parameter int         WORD_BYTES = cpu_pkg::WORD_BYTES,
    parameter logic [3:0] PC_IDX     = cpu_pkg::PC_IDX
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        load_i,
    input  logic        up_i,
    input  logic        pre_i,
    input  logic        wb_i,
    input  logic [3:0]  base_reg_i,
    input  logic [31:0] base_val_i,
    input  logic [15:0] reg_list_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [3:0]  rf_raddr_o,
    input  logic [31:0] rf_rdata_i,
    output logic        rf_we_o,
    output logic [3:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i,
    output logic        pc_we_o,
    output logic [31:0] pc_wdata_o
);

    import cpu_pkg::*;

    localparam logic [31:0] STEP = 32'(WORD_BYTES);

    bts_state_t  state_q, state_d;
    logic [15:0] list_q;
    logic        load_q;
    logic        up_q;
    logic        wb_q;
    logic        base_hit_q;
    logic [3:0]  base_reg_q;
    logic [31:0] base_q;
    logic [4:0]  cnt_q;
    logic [31:0] addr_q;

    logic [3:0]  cur_idx;
    logic        cur_any;
    logic [15:0] list_clr;
    logic        beat_done;
    logic [4:0]  start_cnt;
    logic [31:0] start_span;
    logic [31:0] start_addr;
    logic [31:0] span_q;
    logic [31:0] wb_val;

    lowest_set16 u_lowest (
        .vec (list_q),
        .idx (cur_idx),
        .any (cur_any)
    );

    assign list_clr  = list_q & ~(16'd1 << cur_idx);
    assign beat_done = (state_q == XFER) && mem_ready_i;

    // Lowest register always sits at the lowest address, whichever direction.
    assign start_cnt  = popcount16(reg_list_i);
    assign start_span = STEP * 32'(start_cnt);
    always_comb begin
        start_addr = 32'd0;
        case ({up_i, pre_i})
            2'b11:   start_addr = base_val_i + STEP;
            2'b10:   start_addr = base_val_i;
            2'b01:   start_addr = base_val_i - start_span;
            default: start_addr = base_val_i - start_span + STEP;
        endcase
    end

    assign span_q = STEP * 32'(cnt_q);
    assign wb_val = up_q ? (base_q + span_q) : (base_q - span_q);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            list_q     <= 16'd0;
            load_q     <= 1'b0;
            up_q       <= 1'b0;
            wb_q       <= 1'b0;
            base_hit_q <= 1'b0;
            base_reg_q <= 4'd0;
            base_q     <= 32'd0;
            cnt_q      <= 5'd0;
            addr_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start_i) begin
                list_q     <= reg_list_i;
                load_q     <= load_i;
                up_q       <= up_i;
                wb_q       <= wb_i;
                base_hit_q <= reg_list_i[base_reg_i];
                base_reg_q <= base_reg_i;
                base_q     <= base_val_i;
                cnt_q      <= start_cnt;
                addr_q     <= start_addr;
            end else if (beat_done) begin
                list_q <= list_clr;
                addr_q <= addr_q + STEP;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        done_o      = 1'b0;
        rf_raddr_o  = 4'd0;
        rf_we_o     = 1'b0;
        rf_waddr_o  = 4'd0;
        rf_wdata_o  = 32'd0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'd0;
        mem_wdata_o = 32'd0;
        pc_we_o     = 1'b0;
        pc_wdata_o  = 32'd0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (reg_list_i == 16'd0) ? DONE : XFER;
                end
            end
            XFER: begin
                mem_req_o  = cur_any;
                mem_addr_o = addr_q;
                if (!load_q) begin
                    mem_we_o    = 1'b1;
                    rf_raddr_o  = cur_idx;
                    mem_wdata_o = rf_rdata_i;
                end else if (mem_ready_i) begin
                    if (cur_idx == PC_IDX) begin
                        pc_we_o    = 1'b1;
                        pc_wdata_o = mem_rdata_i;
                    end else begin
                        rf_we_o    = 1'b1;
                        rf_waddr_o = cur_idx;
                        rf_wdata_o = mem_rdata_i;
                    end
                end
                if (mem_ready_i && list_clr == 16'd0) begin
                    state_d = wb_q ? WB : DONE;
                end
            end
            WB: begin
                // A loaded base register keeps the loaded value; the PC is never a writeback target.
                rf_we_o    = (base_reg_q != PC_IDX) && !(load_q && base_hit_q);
                rf_waddr_o = base_reg_q;
                rf_wdata_o = wb_val;
                state_d    = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// tb/tb_block_transfer_sequencer.sv - directed self-checking bench for block_transfer_sequencer
module tb_block_transfer_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        start_i;
    logic        load_i;
    logic        up_i;
    logic        pre_i;
    logic        wb_i;
    logic [3:0]  base_reg_i;
    logic [31:0] base_val_i;
    logic [15:0] reg_list_i;
    logic        busy_o;
    logic        done_o;
    logic [3:0]  rf_raddr_o;
    logic [31:0] rf_rdata_i;
    logic        rf_we_o;
    logic [3:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;
    logic        pc_we_o;
    logic [31:0] pc_wdata_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    // Register file returns 0xBEEF000n for Rn; memory returns the inverted address.
    assign rf_rdata_i  = {16'hBEEF, 12'h000, rf_raddr_o};
    assign mem_rdata_i = ~mem_addr_o;

    block_transfer_sequencer dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .start_i     (start_i),
        .load_i      (load_i),
        .up_i        (up_i),
        .pre_i       (pre_i),
        .wb_i        (wb_i),
        .base_reg_i  (base_reg_i),
        .base_val_i  (base_val_i),
        .reg_list_i  (reg_list_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rf_raddr_o  (rf_raddr_o),
        .rf_rdata_i  (rf_rdata_i),
        .rf_we_o     (rf_we_o),
        .rf_waddr_o  (rf_waddr_o),
        .rf_wdata_o  (rf_wdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ready_i (mem_ready_i),
        .pc_we_o     (pc_we_o),
        .pc_wdata_o  (pc_wdata_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic ld, input logic up, input logic pre, input logic wb,
                          input logic [3:0] breg, input logic [31:0] bval, input logic [15:0] list);
        load_i     = ld;
        up_i       = up;
        pre_i      = pre;
        wb_i       = wb;
        base_reg_i = breg;
        base_val_i = bval;
        reg_list_i = list;
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_req"},  32'(mem_req_o), 32'd0);
        chk({tag, "_rfwe"}, 32'(rf_we_o), 32'd0);
        chk({tag, "_pcwe"}, 32'(pc_we_o), 32'd0);
        chk({tag, "_addr"}, mem_addr_o, 32'd0);
    endtask

    initial begin
        rst_n_i     = 1'b0;
        start_i     = 1'b0;
        load_i      = 1'b0;
        up_i        = 1'b0;
        pre_i       = 1'b0;
        wb_i        = 1'b0;
        base_reg_i  = 4'd0;
        base_val_i  = 32'd0;
        reg_list_i  = 16'd0;
        mem_ready_i = 1'b1;
        tick();
        tick();
        chk_quiet("reset");
        rst_n_i = 1'b1;
        tick();

        // STM R1-R3, up, post, base 0x1000
        launch(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 32'h0000_1000, 16'h000E);
        chk("stm_b0_req",   32'(mem_req_o), 32'd1);
        chk("stm_b0_we",    32'(mem_we_o), 32'd1);
        chk("stm_b0_addr",  mem_addr_o, 32'h0000_1000);
        chk("stm_b0_raddr", 32'(rf_raddr_o), 32'd1);
        chk("stm_b0_wdata", mem_wdata_o, 32'hBEEF_0001);
        chk("stm_b0_busy",  32'(busy_o), 32'd1);
        tick();
        chk("stm_b1_addr",  mem_addr_o, 32'h0000_1004);
        chk("stm_b1_raddr", 32'(rf_raddr_o), 32'd2);
        tick();
        chk("stm_b2_addr",  mem_addr_o, 32'h0000_1008);
        chk("stm_b2_wdata", mem_wdata_o, 32'hBEEF_0003);
        tick();
        chk("stm_done",     32'(done_o), 32'd1);
        chk("stm_done_rfwe", 32'(rf_we_o), 32'd0);
        chk("stm_done_req", 32'(mem_req_o), 32'd0);
        tick();
        chk_quiet("stm_idle");

        // LDM R0,R1,R15, down, pre, writeback into R13 = 0x2000; stray start mid-transfer
        launch(1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 32'h0000_2000, 16'h8003);
        chk("ldm_b0_addr",  mem_addr_o, 32'h0000_1FF4);
        chk("ldm_b0_we",    32'(rf_we_o), 32'd1);
        chk("ldm_b0_waddr", 32'(rf_waddr_o), 32'd0);
        chk("ldm_b0_wdata", rf_wdata_o, 32'hFFFF_E00B);
        chk("ldm_b0_memwe", 32'(mem_we_o), 32'd0);
        start_i    = 1'b1;
        reg_list_i = 16'h00F0;
        tick();
        start_i    = 1'b0;
        chk("ldm_b1_addr",  mem_addr_o, 32'h0000_1FF8);
        chk("ldm_b1_waddr", 32'(rf_waddr_o), 32'd1);
        chk("ldm_b1_wdata", rf_wdata_o, 32'hFFFF_E007);
        tick();
        chk("ldm_b2_addr",  mem_addr_o, 32'h0000_1FFC);
        chk("ldm_b2_rfwe",  32'(rf_we_o), 32'd0);
        chk("ldm_b2_pcwe",  32'(pc_we_o), 32'd1);
        chk("ldm_b2_pcdat", pc_wdata_o, 32'hFFFF_E003);
        tick();
        chk("ldm_wb_we",    32'(rf_we_o), 32'd1);
        chk("ldm_wb_waddr", 32'(rf_waddr_o), 32'd13);
        chk("ldm_wb_wdata", rf_wdata_o, 32'h0000_1FF4);
        chk("ldm_wb_done",  32'(done_o), 32'd0);
        tick();
        chk("ldm_done",     32'(done_o), 32'd1);
        tick();
        chk_quiet("ldm_idle");

        // LDM R4,R5 with base R4 and writeback: loaded value wins
        launch(1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 32'h0000_3000, 16'h0030);
        chk("hit_b0_waddr", 32'(rf_waddr_o), 32'd4);
        chk("hit_b0_wdata", rf_wdata_o, 32'hFFFF_CFFF);
        tick();
        chk("hit_b1_addr",  mem_addr_o, 32'h0000_3004);
        chk("hit_b1_waddr", 32'(rf_waddr_o), 32'd5);
        tick();
        chk("hit_wb_rfwe",  32'(rf_we_o), 32'd0);
        chk("hit_wb_busy",  32'(busy_o), 32'd1);
        chk("hit_wb_done",  32'(done_o), 32'd0);
        tick();
        chk("hit_done",     32'(done_o), 32'd1);
        tick();

        // STM R0,R2, up, pre, writeback R1, 3-cycle stall on the second beat
        launch(1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 32'h0000_4000, 16'h0005);
        chk("stall_b0_addr", mem_addr_o, 32'h0000_4004);
        chk("stall_b0_raddr", 32'(rf_raddr_o), 32'd0);
        tick();
        mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_addr",  mem_addr_o, 32'h0000_4008);
            chk("stall_raddr", 32'(rf_raddr_o), 32'd2);
            chk("stall_req",   32'(mem_req_o), 32'd1);
            chk("stall_rfwe",  32'(rf_we_o), 32'd0);
            tick();
        end
        mem_ready_i = 1'b1;
        chk("stall_resume_addr", mem_addr_o, 32'h0000_4008);
        chk("stall_resume_wdata", mem_wdata_o, 32'hBEEF_0002);
        tick();
        chk("stall_wb_we",    32'(rf_we_o), 32'd1);
        chk("stall_wb_waddr", 32'(rf_waddr_o), 32'd1);
        chk("stall_wb_wdata", rf_wdata_o, 32'h0000_4008);
        tick();
        chk("stall_done",     32'(done_o), 32'd1);
        tick();

        // Empty list: straight to DONE with no beats and no writeback
        launch(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 32'h0000_5000, 16'h0000);
        chk("empty_done", 32'(done_o), 32'd1);
        chk("empty_req",  32'(mem_req_o), 32'd0);
        chk("empty_rfwe", 32'(rf_we_o), 32'd0);
        chk("empty_busy", 32'(busy_o), 32'd1);
        tick();
        chk_quiet("empty_idle");

        // Reset during the second beat abandons the transfer
        launch(1'b1, 1'b1, 1'b0, 1'b0, 4'd8, 32'h0000_5000, 16'h0007);
        tick();
        rst_n_i = 1'b0;
        chk("rst_b1_waddr", 32'(rf_waddr_o), 32'd1);
        tick();
        chk_quiet("rst_abort");
        rst_n_i = 1'b1;
        tick();
        chk_quiet("rst_stay_idle");
        launch(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0000_6000, 16'h0002);
        chk("post_rst_addr",  mem_addr_o, 32'h0000_6000);
        chk("post_rst_raddr", 32'(rf_raddr_o), 32'd1);
        tick();
        chk("post_rst_done",  32'(done_o), 32'd1);
        tick();
        chk_quiet("post_rst_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/block_transfer_sequencer.md
Name: block_transfer_sequencer

Overview:
Multi-cycle sequencer for load/store-multiple instructions (LDM/STM) in the processor core.
- Walks a 16-bit register list and drives the register file read/write ports and the data-memory port one word per beat.
- Performs optional base writeback.
- Holds the pipeline via busy_o until the transfer completes.

Parameters:
WORD_BYTES, 4, address stride per transferred register
PC_IDX, 15, register index routed to the PC path instead of the register file

Ports:
clk_i  in  1  clock; all state changes on rising edge
rst_n_i  in  1  synchronous active-low reset
start_i  in  1  launch request; sampled only in IDLE
load_i  in  1  1 = LDM (memory to registers), 0 = STM
up_i  in  1  1 = increment base, 0 = decrement base
pre_i  in  1  1 = pre-index (before), 0 = post-index (after)
wb_i  in  1  base writeback enable
base_reg_i  in  4  base register index
base_val_i  in  32  base register value
reg_list_i  in  16  register list; bit n selects Rn
busy_o  out  1  high from accepted start until done_o inclusive
done_o  out  1  one-cycle completion pulse
rf_raddr_o  out  4  register file read address (STM data)
rf_rdata_i  in  32  register file read data
rf_we_o  out  1  register file write enable
rf_waddr_o  out  4  register file write address
rf_wdata_o  out  32  register file write data
mem_req_o  out  1  memory beat request
mem_we_o  out  1  memory write (STM)
mem_addr_o  out  32  word address of current beat
mem_wdata_o  out  32  store data; equals rf_rdata_i
mem_rdata_i  in  32  load data; valid with mem_ready_i
mem_ready_i  in  1  beat completes in the cycle mem_req_o and mem_ready_i are both high
pc_we_o  out  1  PC load strobe (LDM including R15)
pc_wdata_o  out  32  PC load value

Behaviour:
- Clock and reset: one clock (clk_i). Reset is synchronous and active-low (rst_n_i).
- Reset: state IDLE and all outputs 0. Latched list, base and count are cleared. Reset mid-transfer abandons the transfer with no further writes.
- States: IDLE, XFER, WB, DONE.
- IDLE to XFER on start_i. Latch the list, flags, base_reg_i and base_val_i; set N = popcount(list).
- start_i outside IDLE is ignored.
- Empty list: IDLE goes straight to DONE. No beats, no writeback.
- Start address A0 (lowest register always at lowest address):
  - up, pre = 1: base + 4
  - up, pre = 0: base
  - down, pre = 1: base - 4N
  - down, pre = 0: base - 4N + 4
- All address arithmetic is 32-bit modulo 2^32; wrap is silent.
- XFER: current register = lowest set bit of the remaining list.
  - mem_req_o = 1, mem_addr_o = A0 + 4*k, where k is the beats completed.
  - STM: mem_we_o = 1, rf_raddr_o = current register. R15 reads return the regfile's r15 path unchanged.
  - LDM, beat completes: rf_we_o = 1, rf_waddr_o = current register, rf_wdata_o = mem_rdata_i, in the same cycle.
  - LDM of R15: rf_we_o stays 0; pc_we_o = 1 and pc_wdata_o = mem_rdata_i instead.
  - On beat completion, clear that bit. When the list is empty, go to WB if wb_i else DONE.
  - mem_ready_i low: hold all outputs stable (stall of any length).
- WB: one cycle.
  - rf_we_o = 1, rf_waddr_o = base_reg, rf_wdata_o = base ± 4N.
  - Suppressed (no write, still one cycle) if base_reg = 15.
  - Also suppressed if load and the base register is in the list; the loaded value wins.
- DONE: done_o = 1 for one cycle, then IDLE. A new start_i is accepted the cycle after DONE.
- Outputs not named for a state are 0.
- Latency: N + 1 + wb + stall cycles from start to done_o.

Decomposition:
- Shared package cpu_pkg:
  - bts_state_t enum (IDLE, XFER, WB, DONE)
  - constants PC_IDX = 4'd15 and WORD_BYTES = 4
  - popcount16 function
- One sub-module: lowest_set16, a combinational 16-bit lowest-set-bit priority encoder with outputs idx[3:0] and any.

Test Plan:
- STM, list 16'h000E, up, post, base 0x1000, ready tied 1 -> writes R1/R2/R3 at 0x1000/0x1004/0x1008; no writeback; done_o at cycle 4.
- LDM, list 16'h8003, down, pre, wb, base R13 = 0x2000 -> addresses 0x1FF4/0x1FF8/0x1FFC; R0, R1 written; pc_we_o with the third word; R13 = 0x1FF4.
- LDM, list includes R4, base R4, wb -> R4 holds the loaded value; no WB write occurs.
- mem_ready_i low for 3 cycles mid-transfer -> mem_addr_o and rf_raddr_o stable; no rf_we_o; resumes correctly.
- Empty list with start -> no mem_req_o; done_o the next cycle. start_i pulsed during XFER -> ignored.
- rst_n_i low during the second beat -> next cycle all outputs 0, IDLE; a subsequent start runs cleanly.
